// File: rtl/sram_write_ctrl_pkg.sv
// spi2hdmi_pkg: shared widths, display defaults and state encoding for the SPI-to-HDMI write path.
package spi2hdmi_pkg;
    localparam int RGB565_W = 16;
    localparam int DISP_W_DEF = 160;
    localparam int DISP_H_DEF = 128;
    localparam int ADDR_W_DEF = 15;
    localparam int FIFO_W_DEF = ADDR_W_DEF + RGB565_W;
    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;
    function automatic int fifo_entry_w(input int aw);
        return aw + RGB565_W;
    endfunction
endpackage

// File: rtl/sram_write_ctrl_if.sv
// sram_write_ctrl_if: decoder requests in, SRAM write port out; slave is the controller side.
interface sram_write_ctrl_if import spi2hdmi_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
    logic [RGB565_W-1:0] i_pixel_data;
    logic [31:0]         i_col_addr;
    logic [31:0]         i_row_addr;
    logic                i_sram_write_req;
    logic                i_sram_waddr_set_req;
    logic                i_sram_clr_req;
    logic                i_sram_ready;
    logic                o_sram_we;
    logic [ADDR_W-1:0]   o_sram_addr;
    logic [RGB565_W-1:0] o_sram_wdata;
    logic                o_busy;
    logic                o_ovf;
    modport slave (
        input  i_pixel_data, i_col_addr, i_row_addr, i_sram_write_req,
               i_sram_waddr_set_req, i_sram_clr_req, i_sram_ready,
        output o_sram_we, o_sram_addr, o_sram_wdata, o_busy, o_ovf
    );
    modport master (
        output i_pixel_data, i_col_addr, i_row_addr, i_sram_write_req,
               i_sram_waddr_set_req, i_sram_clr_req, i_sram_ready,
        input  o_sram_we, o_sram_addr, o_sram_wdata, o_busy, o_ovf
    );
endinterface

// File: rtl/sram_write_ctrl_fifo.sv
// wctrl_fifo: show-ahead FIFO with flush; a push into a full FIFO succeeds when a pop happens in the same cycle.
module wctrl_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 31
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  wr_q, rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(do_push);
            rd_q <= rd_q + (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/sram_write_ctrl.sv
// sram_write_ctrl: windowed pixel cursor -> buffered SRAM writes, plus full-frame clear sweep.
// Optional SRAM_WCTRL_CLIP_EN: drop pixels whose cursor lies outside the display.
module sram_write_ctrl import spi2hdmi_pkg::*; #(
    parameter int              DISP_W     = DISP_W_DEF,
    parameter int              DISP_H     = DISP_H_DEF,
    parameter int              ADDR_W     = ADDR_W_DEF,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [15:0]     CLR_COLOR  = 16'h0000
) (
    input logic              i_clk,
    input logic              i_rst,
    sram_write_ctrl_if.slave bus
);
    localparam int EW = fifo_entry_w(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DISP_W * DISP_H - 1);
    state_e            state_q, state_d;
    logic [15:0]       xs_q, xe_q, ys_q, ye_q, x_q, y_q;
    logic [15:0]       xs_d, xe_d, ys_d, ye_d, x_d, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, ys_base_q, cnt_q, cnt_d, ys_mul;
    logic              rb_load_q, ovf_q, ovf_d;
    logic              clr, wr, clip, push, at_xe, at_ye, full, empty, in_clr;
    logic [EW-1:0]     rdata;
    assign in_clr = state_q == ST_CLEAR;
    assign clr    = bus.i_sram_clr_req;
    assign wr     = ~in_clr & bus.i_sram_write_req & ~clr;
`ifdef SRAM_WCTRL_CLIP_EN
    assign clip   = (x_q >= 16'(DISP_W)) || (y_q >= 16'(DISP_H));
`else
    assign clip   = 1'b0;
`endif
    assign push   = wr & ~clip;
    assign at_xe  = x_q == xe_q;
    assign at_ye  = y_q == ye_q;
    // Row base for the window origin; registered so the multiply never sits on the pixel path.
    assign ys_mul = ADDR_W'(ys_q * DISP_W);
    wctrl_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .flush_i (clr),
        .push_i  (push),
        .pop_i   (~in_clr & bus.i_sram_ready),
        .wdata_i ({row_base_q + ADDR_W'(x_q), bus.i_pixel_data}),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );
    assign bus.o_sram_we    = in_clr | ~empty;
    assign bus.o_sram_addr  = in_clr ? cnt_q : empty ? '0 : rdata[EW-1 -: ADDR_W];
    assign bus.o_sram_wdata = in_clr ? CLR_COLOR : empty ? '0 : rdata[RGB565_W-1:0];
    assign bus.o_busy       = in_clr;
    assign bus.o_ovf        = ovf_q;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        xs_d       = xs_q;
        xe_d       = xe_q;
        ys_d       = ys_q;
        ye_d       = ye_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        if (wr) begin
            x_d        = at_xe ? xs_q : x_q + 16'd1;
            y_d        = !at_xe ? y_q : at_ye ? ys_q : y_q + 16'd1;
            row_base_d = !at_xe ? row_base_q : at_ye ? ys_base_q : row_base_q + ADDR_W'(DISP_W);
            ovf_d      = ovf_q | (push & full & ~bus.i_sram_ready);
        end
        if (rb_load_q) row_base_d = ys_mul;
        // A window update overrides the advance: the concurrent pixel already used the old cursor.
        if (bus.i_sram_waddr_set_req) begin
            xs_d = bus.i_col_addr[31:16];
            xe_d = bus.i_col_addr[15:0] < bus.i_col_addr[31:16] ? bus.i_col_addr[31:16] : bus.i_col_addr[15:0];
            ys_d = bus.i_row_addr[31:16];
            ye_d = bus.i_row_addr[15:0] < bus.i_row_addr[31:16] ? bus.i_row_addr[31:16] : bus.i_row_addr[15:0];
            x_d  = bus.i_col_addr[31:16];
            y_d  = bus.i_row_addr[31:16];
        end
        if (in_clr && bus.i_sram_ready) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == LAST ? ST_IDLE : ST_CLEAR;
        end
        if (clr) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            xs_q       <= '0;
            xe_q       <= '0;
            ys_q       <= '0;
            ye_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            ys_base_q  <= '0;
            rb_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            xs_q       <= xs_d;
            xe_q       <= xe_d;
            ys_q       <= ys_d;
            ye_q       <= ye_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            ys_base_q  <= ys_mul;
            rb_load_q  <= bus.i_sram_waddr_set_req;
        end
    end
endmodule

// File: tb/tb_sram_write_ctrl.sv
// tb_sram_write_ctrl: directed vectors with hand-computed addresses for window, overflow, clear and reset.
module tb_sram_write_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    logic [14:0] qa[$];
    logic [15:0] qd[$];
    sram_write_ctrl_if #(.ADDR_W(15)) bus ();
    sram_write_ctrl u_dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (!rst && bus.o_sram_we && bus.i_sram_ready) begin
            qa.push_back(bus.o_sram_addr);
            qd.push_back(bus.o_sram_wdata);
            acc_cnt++;
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send_px(input logic [15:0] d);
        bus.i_sram_write_req = 1'b1;
        bus.i_pixel_data     = d;
        @(posedge clk);
        #1;
        bus.i_sram_write_req = 1'b0;
    endtask
    task automatic set_win(input logic [15:0] xs, xe, ys, ye);
        bus.i_col_addr = {xs, xe};
        bus.i_row_addr = {ys, ye};
        bus.i_sram_waddr_set_req = 1'b1;
        idle(1);
        bus.i_sram_waddr_set_req = 1'b0;
        idle(2);
    endtask
    task automatic pulse_clr();
        bus.i_sram_clr_req = 1'b1;
        idle(1);
        bus.i_sram_clr_req = 1'b0;
    endtask
    task automatic chk_out_zero(input string tag);
        chk({tag, "_we"}, bus.o_sram_we, 0);
        chk({tag, "_addr"}, bus.o_sram_addr, 0);
        chk({tag, "_wdata"}, bus.o_sram_wdata, 0);
        chk({tag, "_busy"}, bus.o_busy, 0);
        chk({tag, "_ovf"}, bus.o_ovf, 0);
    endtask
    task automatic wait_busy_low(input string tag);
        bit done = 0;
        for (int c = 0; c < 25000 && !done; c++) begin
            @(negedge clk);
            if (!bus.o_busy) done = 1;
        end
        if (!done) chk({tag, "_timeout"}, 0, 1);
    endtask
    initial begin
        int b, bad, n;
        bit got;
        logic [14:0] ea[7] = '{162, 163, 164, 322, 323, 324, 162};
        bus.i_pixel_data = '0;
        bus.i_col_addr = '0;
        bus.i_row_addr = '0;
        bus.i_sram_write_req = 1'b0;
        bus.i_sram_waddr_set_req = 1'b0;
        bus.i_sram_clr_req = 1'b0;
        bus.i_sram_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk_out_zero("rst");
        idle(1);
        // Window walk with wrap back to the origin
        set_win(2, 4, 1, 2);
        b = qa.size();
        for (int i = 1; i <= 7; i++) send_px(16'(i * 16'h1111));
        idle(4);
        chk("win_n", qa.size() - b, 7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("win_addr%0d", i), qa[b+i], ea[i]);
            chk($sformatf("win_data%0d", i), qd[b+i], (i + 1) * 16'h1111);
        end
        // XS>XE collapses to a one-pixel column
        set_win(5, 3, 0, 0);
        b = qa.size();
        send_px(16'hBEEF);
        send_px(16'hCAFE);
        idle(3);
        chk("swap_n", qa.size() - b, 2);
        chk("swap_a0", qa[b], 5);
        chk("swap_a1", qa[b+1], 5);
        // Overflow with a stalled arbiter
        bus.i_sram_ready = 1'b0;
        set_win(10, 19, 3, 3);
        b = qa.size();
        for (int i = 0; i < 6; i++) send_px(16'(16'hA000 + i));
        @(negedge clk);
        chk("ovf_flag", bus.o_ovf, 1);
        chk("ovf_hold_we", bus.o_sram_we, 1);
        chk("ovf_hold_addr", bus.o_sram_addr, 490);
        chk("ovf_hold_data", bus.o_sram_wdata, 16'hA000);
        idle(1);
        bus.i_sram_ready = 1'b1;
        idle(8);
        chk("ovf_n", qa.size() - b, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_addr%0d", i), qa[b+i], 490 + i);
            chk($sformatf("ovf_data%0d", i), qd[b+i], 16'hA000 + i);
        end
        chk("ovf_drained", bus.o_sram_we, 0);
        // Clear sweep with two pending pixels
        bus.i_sram_ready = 1'b0;
        send_px(16'h1234);
        send_px(16'h5678);
        pulse_clr();
        @(negedge clk);
        chk("clr_busy", bus.o_busy, 1);
        chk("clr_we", bus.o_sram_we, 1);
        chk("clr_addr0", bus.o_sram_addr, 0);
        chk("clr_data0", bus.o_sram_wdata, 0);
        chk("clr_ovf", bus.o_ovf, 0);
        idle(1);
        b = qa.size();
        bus.i_sram_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 25000 && !got; c++) begin
            @(negedge clk);
            if (bus.o_busy && bus.o_sram_addr == 15'd20479) begin
                got = 1;
                @(negedge clk);
                chk("clr_busy_fall", bus.o_busy, 0);
            end
        end
        if (!got) chk("clr_timeout", 0, 1);
        chk("clr_n", qa.size() - b, 20480);
        bad = 0;
        for (int i = 0; i < qa.size() - b; i++)
            if (qa[b+i] != 15'(i) || qd[b+i] != 16'h0000) bad++;
        chk("clr_seq", bad, 0);
        chk("clr_flushed", bus.o_sram_we, 0);
        idle(1);
        // Restart the sweep just before address 100 is accepted
        b = acc_cnt;
        pulse_clr();
        got = 0;
        for (int c = 0; c < 500 && !got; c++) begin
            @(negedge clk);
            if (bus.o_sram_addr == 15'd99) got = 1;
        end
        if (!got) chk("rs_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.i_sram_ready = 1'b0;
        bus.i_sram_clr_req = 1'b1;
        @(negedge clk);
        chk("rs_addr100", bus.o_sram_addr, 100);
        chk("rs_acc100", acc_cnt - b, 100);
        @(posedge clk);
        #1;
        bus.i_sram_clr_req = 1'b0;
        bus.i_sram_ready = 1'b1;
        @(negedge clk);
        chk("rs_addr0", bus.o_sram_addr, 0);
        wait_busy_low("rs");
        chk("rs_total", acc_cnt - b, 20580);
        idle(1);
        // Clip of pixels past the right edge
        set_win(158, 161, 0, 0);
        b = qa.size();
        for (int i = 0; i < 4; i++) send_px(16'(16'hC000 + i));
        idle(4);
`ifdef SRAM_WCTRL_CLIP_EN
        n = 2;
`else
        n = 4;
`endif
        chk("clip_n", qa.size() - b, n);
        for (int i = 0; i < n && b + i < qa.size(); i++)
            chk($sformatf("clip_addr%0d", i), qa[b+i], 158 + i);
        chk("clip_ovf", bus.o_ovf, 0);
        // Reset in the middle of a sweep
        pulse_clr();
        idle(50);
        @(negedge clk);
        chk("mid_busy", bus.o_busy, 1);
        rst = 1'b1;
        #1;
        chk_out_zero("mrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        @(negedge clk);
        chk("post_rst_we", bus.o_sram_we, 0);
        chk("post_rst_busy", bus.o_busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
